// File: rtl/rst_seq_gen_if.sv
// Reset sequencer bundle: the software reset request going in, the staged
// reset outputs with their done flag and the FSM state coming out.
interface rst_seq_gen_if #(
    parameter int NUM_OUT = 4
);
    logic               sw_rst_req;
    logic [NUM_OUT-1:0] rst_out;
    logic               done;
    logic [1:0]         dbg_state;

    modport master (
        input  sw_rst_req,
        output rst_out,
        output done,
        output dbg_state
    );

    modport slave (
        output sw_rst_req,
        input  rst_out,
        input  done,
        input  dbg_state
    );
endinterface

// File: rtl/rst_seq_gen.sv
// Reset source and sequencer: holds every rst_out bit for HOLD_CYCLES after reset
// or a software request, then releases them one by one, STAGE_GAP cycles apart.
module rst_seq_gen #(
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic          clk,
    input  logic          rst,
    rst_seq_gen_if.master bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_OUT + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

    if (NUM_OUT < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_bad_params
        $error("rst_seq_gen: NUM_OUT, HOLD_CYCLES and STAGE_GAP must all be >= 1");
    end

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_STAGE = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
    logic               done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        rst_out_d = rst_out_q;
        done_d    = done_q;

        // The software request wins over everything, including a release due this edge.
        if (bus.sw_rst_req) begin
            state_d   = ST_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            rst_out_d = '1;
            done_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    rst_out_d = '1;
                    done_d    = 1'b0;
                    if (cnt_q == HOLD_LAST) begin
                        rst_out_d[0] = 1'b0;
                        cnt_d        = '0;
                        idx_d        = IW'(1);
                        if (NUM_OUT == 1) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_STAGE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_STAGE: begin
                    if (cnt_q == GAP_LAST) begin
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (IW'(i) == idx_q) rst_out_d[i] = 1'b0;
                        end
                        cnt_d = '0;
                        idx_d = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    rst_out_d = '0;
                    done_d    = 1'b1;
                end
                default: begin
                    state_d   = ST_HOLD;
                    cnt_d     = '0;
                    idx_d     = '0;
                    rst_out_d = '1;
                    done_d    = 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_out   = rst_out_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default config plus two small configs sharing rst,
// with release edges computed from HOLD + k*GAP.
module tb_rst_seq_gen;
    logic clk;
    logic rst;

    rst_seq_gen_if #(.NUM_OUT(4)) if0 ();
    rst_seq_gen_if #(.NUM_OUT(1)) if1 ();
    rst_seq_gen_if #(.NUM_OUT(3)) if2 ();

    rst_seq_gen #(.NUM_OUT(4), .HOLD_CYCLES(16), .STAGE_GAP(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.master)
    );
    rst_seq_gen #(.NUM_OUT(1), .HOLD_CYCLES(1), .STAGE_GAP(3)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.master)
    );
    rst_seq_gen #(.NUM_OUT(3), .HOLD_CYCLES(2), .STAGE_GAP(1)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_rst(input int e, input int n, input int h, input int g);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = (e < h + k * g);
        return v;
    endfunction

    function automatic logic exp_done(input int e, input int n, input int h, input int g);
        return (e >= h + (n - 1) * g);
    endfunction

    // Edges 1..45 after a release point; all_duts also checks the small configs.
    task automatic run_seq(input string name, input bit all_duts);
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("%s d0 rst_out e%0d", name, e), 32'(if0.rst_out), 32'(exp_rst(e, 4, 16, 8)));
            check_val($sformatf("%s d0 done e%0d", name, e), 32'(if0.done), 32'(exp_done(e, 4, 16, 8)));
            if (all_duts) begin
                check_val($sformatf("%s d1 rst_out e%0d", name, e), 32'(if1.rst_out), 32'(exp_rst(e, 1, 1, 3)));
                check_val($sformatf("%s d1 done e%0d", name, e), 32'(if1.done), 32'(exp_done(e, 1, 1, 3)));
                check_val($sformatf("%s d2 rst_out e%0d", name, e), 32'(if2.rst_out), 32'(exp_rst(e, 3, 2, 1)));
                check_val($sformatf("%s d2 done e%0d", name, e), 32'(if2.done), 32'(exp_done(e, 3, 2, 1)));
            end
        end
        check_val($sformatf("%s d0 state run", name), 32'(if0.dbg_state), 32'd2);
    endtask

    // Hold sw_rst_req for len sampling edges; the last one becomes edge 0.
    task automatic sw_req(input string name, input int len);
        if0.sw_rst_req = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("%s held rst_out %0d", name, i), 32'(if0.rst_out), 32'hf);
            check_val($sformatf("%s held done %0d", name, i), 32'(if0.done), 32'd0);
        end
        if0.sw_rst_req = 1'b0;
        run_seq(name, 1'b0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if0.sw_rst_req = 1'b0;
        if1.sw_rst_req = 1'b0;
        if2.sw_rst_req = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check_val("reset d0 rst_out", 32'(if0.rst_out), 32'hf);
        check_val("reset d0 done", 32'(if0.done), 32'd0);
        check_val("reset d0 state", 32'(if0.dbg_state), 32'd0);
        check_val("reset d1 rst_out", 32'(if1.rst_out), 32'h1);
        check_val("reset d2 rst_out", 32'(if2.rst_out), 32'h7);
        check_val("reset d2 done", 32'(if2.done), 32'd0);

        release_rst();
        run_seq("por", 1'b1);

        sw_req("sw_pulse", 1);
        sw_req("sw_held", 50);

        // Async reset in the middle of STAGE, with no clock edge in between.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();
        for (int e = 1; e <= 25; e++) @(posedge clk);
        #1;
        check_val("mid_stage rst_out before", 32'(if0.rst_out), 32'hc);
        #3;
        rst = 1'b1;
        #1;
        check_val("async rst_out", 32'(if0.rst_out), 32'hf);
        check_val("async done", 32'(if0.done), 32'd0);
        check_val("async d2 rst_out", 32'(if2.rst_out), 32'h7);
        repeat (3) @(negedge clk);
        release_rst();
        run_seq("after_async", 1'b1);

        // Request lands exactly on the edge where bit 2 would fall.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        release_rst();
        for (int e = 1; e <= 31; e++) @(posedge clk);
        #1;
        check_val("pre_bit2 rst_out", 32'(if0.rst_out), 32'hc);
        sw_req("sw_on_bit2", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
- Reset source and sequencer for a clock domain.
- Takes the domain's asynchronous reset plus a synchronous software reset request.
- Holds all downstream reset outputs asserted for a minimum time, then releases them one at a time in index order with a fixed gap.
- Outputs are glitch-free registers intended to drive downstream per-domain reset synchronizers and subsystem resets; `done` reports that sequencing is complete.

Parameters:
- NUM_OUT, 4: number of sequenced reset outputs (>=1).
- HOLD_CYCLES, 16: clk cycles all outputs stay asserted after reset/request release (>=1).
- STAGE_GAP, 8: clk cycles between successive output deassertions (>=1).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- sw_rst_req  input  1  synchronous software reset request, level-sensitive, sampled on clk.
- rst_out  output  NUM_OUT  active-high reset outputs, bit 0 released first.
- done  output  1  high when all rst_out bits are deasserted.

Behaviour:
- Outputs:
  - All outputs are registered; no combinational path from any input to any output.
  - rst = 1 asynchronously forces rst_out = all ones, done = 0, state HOLD, cnt = 0, idx = 0.
- Counters:
  - cnt width is $clog2(max(HOLD_CYCLES, STAGE_GAP)+1).
  - idx width is $clog2(NUM_OUT+1).
  - Neither counter may wrap in normal operation.
- States:
  - HOLD, STAGE, RUN; registered state encoding.
- HOLD:
  - rst_out = all ones, done = 0.
  - cnt increments each edge.
  - On the edge where cnt == HOLD_CYCLES-1:
    - clear rst_out[0] and set cnt = 0, idx = 1.
    - If NUM_OUT == 1: go to RUN and set done = 1 on the same edge.
    - Otherwise: go to STAGE.
- STAGE:
  - cnt increments each edge.
  - On the edge where cnt == STAGE_GAP-1:
    - clear rst_out[idx], set cnt = 0, idx = idx+1.
    - If idx == NUM_OUT-1 before the increment: go to RUN and set done = 1 on the same edge.
- RUN:
  - Holds rst_out = 0, done = 1 indefinitely.
- Resulting timing (edges counted from the first clk edge after rst deasserts, edge 1 = first):
  - rst_out[k] falls on edge HOLD_CYCLES + k*STAGE_GAP.
  - done rises on the same edge as rst_out[NUM_OUT-1] falls.
- sw_rst_req = 1 on a sampling edge, in any state:
  - next state HOLD, rst_out = all ones, done = 0, cnt = 0, idx = 0.
  - Priority over all other transitions, including a release scheduled for that edge.
- Holding sw_rst_req high keeps cnt at 0, extending the reset for as long as the request is high.
- Release timing after sw_rst_req:
  - Take the last edge on which sw_rst_req is sampled high as edge 0.
  - rst_out[0] falls on edge HOLD_CYCLES after it.
- Assertion order: rst_out bits are only ever asserted all together; deassertion is strictly one bit per release edge, in ascending index.
- Monotonic: once released, a bit never re-asserts except via rst or sw_rst_req.
- rst mid-sequence (any state): immediate asynchronous return to the reset values; the full sequence restarts on release.
- Elaboration error if NUM_OUT, HOLD_CYCLES or STAGE_GAP is < 1.

Test Plan:
- Defaults; rst high 5 cycles then low -> rst_out[0] falls edge 16, [1] edge 24, [2] edge 32, [3] edge 40; done rises edge 40; before edge 16 rst_out = 4'b1111, done = 0.
- In RUN, pulse sw_rst_req for 1 cycle at edge 0 -> rst_out = 4'b1111 and done = 0 from edge 1; rst_out[0] falls at edge 16, done rises at edge 40.
- sw_rst_req held high 50 cycles -> rst_out stays 4'b1111 throughout; rst_out[0] falls 16 edges after the last high sample.
- rst asserted asynchronously mid-STAGE (rst_out = 4'b1100) -> rst_out = 4'b1111 and done = 0 immediately, without waiting for a clk edge; full 16/24/32/40 sequence repeats after release.
- sw_rst_req asserted exactly on the edge where rst_out[2] would fall -> rst_out returns to 4'b1111 and bit 2 never falls; the sequence restarts.
- NUM_OUT=1, HOLD_CYCLES=1, STAGE_GAP=3 -> rst_out and done both change on edge 1 after rst release.
- NUM_OUT=3, HOLD_CYCLES=2, STAGE_GAP=1 -> bits fall on edges 2, 3, 4; done rises on edge 4.
